// File: rtl/ppwm_prog_loader.sv
// Programming front end for the ppwm core: buffers host instruction words in a
// small FIFO and serialises each one as start bit, LSB-first data, low gap.
module ppwm_prog_loader #(
  parameter int INSTR_WIDTH = 7,
  parameter int NUM_WORDS   = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  input  logic [INSTR_WIDTH-1:0]         instr_i,
  input  logic                           instr_valid_i,
  output logic                           instr_ready_o,
  output logic                           data_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [$clog2(NUM_WORDS+1)-1:0] word_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int BW = $clog2(INSTR_WIDTH + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [OW-1:0] FULL_OCC = OW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS - 1);
  localparam logic [BW-1:0] BITS     = BW'(INSTR_WIDTH);
  localparam logic [BW-1:0] ONE_BIT  = BW'(1);
  localparam logic [GW-1:0] GAPS     = GW'(GAP_CYCLES);
  localparam logic [GW-1:0] ONE_GAP  = GW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [OW-1:0]          occ;
  logic [INSTR_WIDTH-1:0] shift;
  logic [BW-1:0]          bit_cnt;
  logic [GW-1:0]          gap_cnt;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  // Ready comes only from registered occupancy, so a same-cycle pop never raises it.
  assign full          = (occ == FULL_OCC);
  assign empty         = (occ == '0);
  assign instr_ready_o = !full;
  assign push          = instr_valid_i && !full && !clear_i;
  assign pop           = (state == IDLE) && !empty && !clear_i;
  assign busy_o        = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= instr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  // data_o is registered alongside the state, so it always reflects the state being entered.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state      <= IDLE;
      data_o     <= 1'b0;
      done_o     <= 1'b0;
      word_cnt_o <= '0;
      shift      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= mem[rd_ptr];
            bit_cnt <= BITS;
            data_o  <= 1'b1;
            state   <= START;
          end else begin
            data_o <= 1'b0;
          end
        end
        START: begin
          data_o <= shift[0];
          shift  <= shift >> 1;
          state  <= DATA;
        end
        DATA: begin
          if (bit_cnt == ONE_BIT) begin
            data_o  <= 1'b0;
            gap_cnt <= GAPS;
            state   <= GAP;
            // Completing the image wraps the count and flags the round.
            if (word_cnt_o == LAST_CNT) begin
              word_cnt_o <= '0;
              done_o     <= 1'b1;
            end else begin
              word_cnt_o <= word_cnt_o + 1'b1;
            end
          end else begin
            data_o  <= shift[0];
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        GAP: begin
          data_o <= 1'b0;
          if (gap_cnt == ONE_GAP) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          data_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppwm_prog_loader.sv
// Directed, table-driven bench for ppwm_prog_loader: frame shape, backpressure,
// full-image done pulse, clear and mid-frame reset.
module tb_ppwm_prog_loader;

  logic       clk;
  logic       rst;
  logic       clear;
  logic [6:0] instr;
  logic       valid;
  logic       ready;
  logic       data;
  logic       busy;
  logic       done;
  logic [4:0] word_cnt;

  int n_tests;
  int n_fail;
  int cycle;
  int done_count;
  int done_base;
  int first_stall;
  logic [6:0] seq[$];

  typedef struct {
    logic [6:0] word;
    logic [7:0] frame;
    logic [4:0] cnt;
  } vec_t;

  vec_t vecs[6];

  ppwm_prog_loader dut (
    .clk           (clk),
    .rst           (rst),
    .clear_i       (clear),
    .instr_i       (instr),
    .instr_valid_i (valid),
    .instr_ready_o (ready),
    .data_o        (data),
    .busy_o        (busy),
    .done_o        (done),
    .word_cnt_o    (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial done_count = 0;
  always @(negedge clk) if (done === 1'b1) done_count <= done_count + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst   = 1'b1;
    clear = 1'b0;
    valid = 1'b0;
    instr = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pushWord(input logic [6:0] w);
    @(negedge clk);
    instr = w;
    valid = 1'b1;
    checkOutput("push_ready", ready, 1);
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Holds valid high through the queued words; records the index of the first stall.
  task automatic pushSeq();
    first_stall = -1;
    foreach (seq[i]) begin
      int waited;
      bit acc;
      waited = 0;
      do begin
        @(negedge clk);
        instr = seq[i];
        valid = 1'b1;
        acc   = ready;
        if (!acc && first_stall < 0) first_stall = i;
        @(posedge clk);
        waited++;
      end while (!acc && waited < 40);
      if (!acc) checkOutput("push_accept_timeout", acc, 1);
    end
    #1 valid = 1'b0;
  endtask

  task automatic captureFrame(output logic [6:0] w, output int start, output bit ok);
    int waited;
    waited = 0;
    ok     = 1'b0;
    w      = '0;
    start  = -1;
    @(negedge clk);
    while (data !== 1'b1 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (data === 1'b1) begin
      start = cycle;
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        w[i] = data;
      end
      ok = 1'b1;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0] got;
    pushWord(v.word);
    @(negedge clk);
    checkOutput("pre_start_data", data, 0);
    checkOutput("pre_start_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      got[7-i] = data;
    end
    checkOutput("frame_bits", got, v.frame);
    @(negedge clk);
    checkOutput("gap_data", data, 0);
    checkOutput("gap_word_cnt", word_cnt, v.cnt);
    checkOutput("gap_busy", busy, 1);
    @(negedge clk);
    checkOutput("idle_data", data, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  task automatic watchIdle(input string name, input int cycles);
    int highs;
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (data !== 1'b0 || done !== 1'b0) highs++;
    end
    checkOutput(name, highs, 0);
  endtask

  initial begin
    logic [6:0] w;
    int st;
    int prev;
    bit ok;

    n_tests = 0;
    n_fail  = 0;

    // Frames in time order, left bit first: start bit then data LSB first.
    vecs[0] = '{7'h55, 8'b1101_0101, 5'd1};
    vecs[1] = '{7'h01, 8'b1100_0000, 5'd2};
    vecs[2] = '{7'h7F, 8'b1111_1111, 5'd3};
    vecs[3] = '{7'h00, 8'b1000_0000, 5'd4};
    vecs[4] = '{7'h40, 8'b1000_0001, 5'd5};
    vecs[5] = '{7'h2A, 8'b1010_1010, 5'd6};

    doReset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_data", data, 0);
      checkOutput("reset_ready", ready, 1);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_word_cnt", word_cnt, 0);
    end

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Backpressure: six words with valid held high.
    seq = '{7'h11, 7'h22, 7'h33, 7'h44, 7'h55, 7'h66};
    fork
      pushSeq();
      begin
        prev = -1;
        for (int k = 0; k < 6; k++) begin
          captureFrame(w, st, ok);
          checkOutput("bp_frame_seen", ok, 1);
          checkOutput("bp_word", w, seq[k]);
          if (k > 0) checkOutput("bp_period", st - prev, 10);
          prev = st;
        end
      end
    join
    checkOutput("bp_accepted_before_stall", first_stall, 5);
    watchIdle("bp_no_extra_frame", 15);

    // Full image of sixteen words, then one more.
    doReset();
    done_base = done_count;
    seq.delete();
    for (int k = 0; k < 16; k++) seq.push_back(7'(k));
    fork
      pushSeq();
      begin
        for (int k = 0; k < 16; k++) begin
          captureFrame(w, st, ok);
          checkOutput("img_frame_seen", ok, 1);
          checkOutput("img_word", w, k);
          if (k == 15) begin
            checkOutput("img_no_early_done", done_count - done_base, 0);
            checkOutput("img_cnt_last_bit", word_cnt, 15);
            @(negedge clk);
            checkOutput("img_done_pulse", done, 1);
            checkOutput("img_cnt_wrapped", word_cnt, 0);
            @(negedge clk);
            checkOutput("img_done_one_cycle", done, 0);
          end
        end
      end
    join
    checkOutput("img_done_count", done_count - done_base, 1);
    pushWord(7'h11);
    captureFrame(w, st, ok);
    checkOutput("img17_word", w, 7'h11);
    @(negedge clk);
    checkOutput("img17_cnt", word_cnt, 1);
    checkOutput("img17_no_done", done, 0);
    checkOutput("img17_done_count", done_count - done_base, 1);

    // Clear during the 3rd data bit of word 2 with two words queued.
    doReset();
    done_base = done_count;
    seq = '{7'h11, 7'h7F, 7'h33, 7'h44};
    fork
      pushSeq();
      begin
        captureFrame(w, st, ok);
        checkOutput("clr_word1", w, 7'h11);
      end
    join
    begin
      int waited;
      waited = 0;
      @(negedge clk);
      while (data !== 1'b1 && waited < 30) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("clr_word2_start", data, 1);
    end
    repeat (3) @(negedge clk);
    checkOutput("clr_bit3_high", data, 1);
    clear = 1'b1;
    valid = 1'b1;
    instr = 7'h5A;
    @(posedge clk);
    #1;
    clear = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    checkOutput("clr_data", data, 0);
    checkOutput("clr_busy", busy, 0);
    checkOutput("clr_ready", ready, 1);
    checkOutput("clr_word_cnt", word_cnt, 0);
    checkOutput("clr_done", done, 0);
    watchIdle("clr_queue_flushed", 15);
    checkOutput("clr_no_done_pulse", done_count - done_base, 0);
    pushWord(7'h01);
    captureFrame(w, st, ok);
    checkOutput("clr_new_word", w, 7'h01);
    @(negedge clk);
    checkOutput("clr_new_cnt", word_cnt, 1);

    // Reset asserted in START, alone and together with clear.
    for (int mode = 0; mode < 2; mode++) begin
      seq = '{7'h15, 7'h2B, 7'h3C};
      fork
        pushSeq();
        begin
          int waited;
          waited = 0;
          @(negedge clk);
          while (data !== 1'b1 && waited < 30) begin
            @(negedge clk);
            waited++;
          end
          checkOutput("rst_mid_start_seen", data, 1);
          rst   = 1'b1;
          clear = (mode == 1);
          @(posedge clk);
          #1;
          rst   = 1'b0;
          clear = 1'b0;
        end
      join
      @(negedge clk);
      checkOutput("rst_mid_data", data, 0);
      checkOutput("rst_mid_ready", ready, 1);
      checkOutput("rst_mid_busy", busy, 0);
      checkOutput("rst_mid_done", done, 0);
      checkOutput("rst_mid_word_cnt", word_cnt, 0);
      watchIdle("rst_mid_queue_dropped", 15);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
